reg_file_param: RTL

//   Parametrised successor to the 32x32 two-read register file. Generic width,

---
 rtl/reg_file_param_if.sv | 31 +++
 rtl/reg_file_param.sv | 119 +++++++++++
 2 files changed

// File: rtl/reg_file_param_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_param_if
// Description : Bus bundle for reg_file_param: write port, scrub request,
//               packed read-address/read-data vectors and ready flag.
// Revision    : 1.0  initial release
// ============================================================================
interface reg_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) ();
    logic                      clr;
    logic                      we;
    logic [ADDR_W-1:0]         rd;
    logic [DATA_W-1:0]         indata;
    logic [NREAD*ADDR_W-1:0]   rs;
    logic [NREAD*DATA_W-1:0]   rv;
    logic                      ready;

    modport master (
        output clr, we, rd, indata, rs,
        input  rv, ready
    );

    modport slave (
        input  clr, we, rd, indata, rs,
        output rv, ready
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_param
// Description : Parametrised multi-read register file with optional zero
//               register, optional write bypass and a sequential scrub FSM.
// Revision    : 1.0  initial release
// ============================================================================
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    reg_file_param_if.slave    bus
);

    localparam int                c_depth    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_ptr = {ADDR_W{1'b1}};

    localparam logic [0:0] c_st_clear = 1'b0;
    localparam logic [0:0] c_st_idle  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;
    logic              r_ready;
    logic              w_ready_nxt;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] r_mem [c_depth];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_clear;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    // A single storage write port is shared by the scrubber and the user;
    // the scrubber owns it for the whole CLEAR phase.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_ready_nxt   = r_ready;
        w_mem_we      = 1'b0;
        w_mem_addr    = bus.rd;
        w_mem_data    = bus.indata;
        case (r_state)
            c_st_clear: begin
                w_mem_we      = 1'b1;
                w_mem_addr    = r_clr_ptr;
                w_mem_data    = '0;
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == c_last_ptr) begin
                    w_state_nxt = c_st_idle;
                    w_ready_nxt = 1'b1;
                end
            end
            c_st_idle: begin
                if (bus.clr) begin
                    w_state_nxt   = c_st_clear;
                    w_clr_ptr_nxt = '0;
                    w_ready_nxt   = 1'b0;
                end else if (bus.we && !((ZERO_REG != 0) && (bus.rd == '0))) begin
                    w_mem_we = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = c_st_clear;
                w_clr_ptr_nxt = '0;
                w_ready_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    assign bus.ready = r_ready;

    // r_ready is high exactly in IDLE, so it doubles as the read-enable.
    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [ADDR_W-1:0] w_rs;
        logic [DATA_W-1:0] w_rv;

        assign w_rs = bus.rs[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_rv = '0;
            if (r_ready) begin
                if ((ZERO_REG != 0) && (w_rs == '0)) begin
                    w_rv = '0;
                end else if ((BYPASS != 0) && bus.we && (bus.rd == w_rs)) begin
                    w_rv = bus.indata;
                end else begin
                    w_rv = r_mem[w_rs];
                end
            end
        end

        assign bus.rv[k*DATA_W +: DATA_W] = w_rv;
    end

endmodule
`default_nettype wire
